// File: rtl/mat_inst_loader.sv
// mat_inst_loader: streams a host program into mat_control's instruction
// memory from address 0, releases the controller from reset once the full
// program is written, and supervises the run until done or timeout.
module mat_inst_loader #(
  parameter int INST_WIDTH    = 32,
  parameter int INST_MEM_SIZE = 256,
  parameter int RUN_TIMEOUT   = 4096,
  parameter int ADDR_SIZE     = $clog2(INST_MEM_SIZE)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  mem_write_en,
  output logic [ADDR_SIZE-1:0]  mem_write_addr,
  output logic [INST_WIDTH-1:0] mem_write_data,
  output logic                  ctrl_reset,
  input  logic                  ctrl_done,
  output logic                  busy,
  output logic                  run_done,
  output logic [31:0]           run_cycles,
  output logic [ADDR_SIZE:0]    inst_count,
  output logic                  err_overflow,
  output logic                  err_timeout
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [ADDR_SIZE:0] LP_FULL    = (ADDR_SIZE+1)'(INST_MEM_SIZE);
  localparam logic [31:0]        LP_TIMEOUT = 32'(RUN_TIMEOUT);

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic                  w_beat;
  logic                  w_full;
  logic [31:0]           w_run_next;
  logic                  w_timeout;
  logic [31:0]           r_run_ctr;
  logic                  r_mem_write_en;
  logic [ADDR_SIZE-1:0]  r_mem_write_addr;
  logic [INST_WIDTH-1:0] r_mem_write_data;
  logic                  r_ctrl_reset;
  logic                  r_busy;
  logic                  r_run_done;
  logic [31:0]           r_run_cycles;
  logic [ADDR_SIZE:0]    r_inst_count;
  logic                  r_err_overflow;
  logic                  r_err_timeout;

  // Host may push words only while a program is being received or discarded.
  assign in_ready   = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign w_beat     = in_valid & in_ready;
  assign w_full     = (r_inst_count == LP_FULL);
  assign w_run_next = r_run_ctr + 32'd1;
  assign w_timeout  = (w_run_next == LP_TIMEOUT);

  // Next-state decode of the load/run sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_beat) w_next = in_last ? S_RELEASE : S_LOAD;
      S_LOAD: begin
        if (w_beat) begin
          if (w_full)       w_next = in_last ? S_IDLE : S_DRAIN;
          else if (in_last) w_next = S_RELEASE;
        end
      end
      S_DRAIN:   if (w_beat && in_last) w_next = S_IDLE;
      S_RELEASE: w_next = S_RUN;
      S_RUN: begin
        if (ctrl_done)      w_next = S_DONE;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Registered state, memory write port, controller reset and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_run_ctr        <= '0;
      r_mem_write_en   <= 1'b0;
      r_mem_write_addr <= '0;
      r_mem_write_data <= '0;
      r_ctrl_reset     <= 1'b1;
      r_busy           <= 1'b0;
      r_run_done       <= 1'b0;
      r_run_cycles     <= '0;
      r_inst_count     <= '0;
      r_err_overflow   <= 1'b0;
      r_err_timeout    <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_busy         <= (w_next != S_IDLE);
      r_mem_write_en <= 1'b0;
      r_run_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_beat) begin
            r_err_overflow   <= 1'b0;
            r_err_timeout    <= 1'b0;
            r_mem_write_en   <= 1'b1;
            r_mem_write_addr <= '0;
            r_mem_write_data <= in_data;
            r_inst_count     <= (ADDR_SIZE+1)'(1);
          end
        end
        S_LOAD: begin
          if (w_beat) begin
            // A word beyond the memory depth is dropped and flagged.
            if (w_full) begin
              r_err_overflow <= 1'b1;
            end else begin
              r_mem_write_en   <= 1'b1;
              r_mem_write_addr <= r_inst_count[ADDR_SIZE-1:0];
              r_mem_write_data <= in_data;
              r_inst_count     <= r_inst_count + 1'b1;
            end
          end
        end
        S_RELEASE: r_run_ctr <= '0;
        S_RUN: begin
          // ctrl_reset drops one cycle after RUN entry so the final write lands first.
          r_run_ctr    <= w_run_next;
          r_ctrl_reset <= 1'b0;
          if (ctrl_done) begin
            r_run_cycles <= w_run_next;
            r_run_done   <= 1'b1;
            r_ctrl_reset <= 1'b1;
          end else if (w_timeout) begin
            r_err_timeout <= 1'b1;
            r_ctrl_reset  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_write_en   = r_mem_write_en;
  assign mem_write_addr = r_mem_write_addr;
  assign mem_write_data = r_mem_write_data;
  assign ctrl_reset     = r_ctrl_reset;
  assign busy           = r_busy;
  assign run_done       = r_run_done;
  assign run_cycles     = r_run_cycles;
  assign inst_count     = r_inst_count;
  assign err_overflow   = r_err_overflow;
  assign err_timeout    = r_err_timeout;

endmodule

// File: tb/tb_mat_inst_loader.sv
// Directed bench for mat_inst_loader with a small memory and short timeout.
module tb_mat_inst_loader;

  localparam int IW   = 32;
  localparam int MEMS = 16;
  localparam int TMO  = 16;
  localparam int AW   = $clog2(MEMS);

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          mem_write_en;
  logic [AW-1:0] mem_write_addr;
  logic [IW-1:0] mem_write_data;
  logic          ctrl_reset;
  logic          ctrl_done;
  logic          busy;
  logic          run_done;
  logic [31:0]   run_cycles;
  logic [AW:0]   inst_count;
  logic          err_overflow;
  logic          err_timeout;

  mat_inst_loader #(
    .INST_WIDTH(IW), .INST_MEM_SIZE(MEMS), .RUN_TIMEOUT(TMO)
  ) dut (
    .clock(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .ctrl_reset(ctrl_reset), .ctrl_done(ctrl_done),
    .busy(busy), .run_done(run_done), .run_cycles(run_cycles),
    .inst_count(inst_count), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_pulses;
  int crst_low;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];

  always @(posedge clk) cyc++;

  // Observe outputs on the falling edge, away from the launching edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_write_en) begin
        wr_addr.push_back(int'(mem_write_addr));
        wr_data.push_back(int'(mem_write_data));
        wr_cyc.push_back(cyc);
      end
      if (run_done)    done_pulses++;
      if (!ctrl_reset) crst_low++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_pulses = 0;
    crst_low    = 0;
  endtask

  task automatic send_word(input logic [IW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    ctrl_done = 1'b0;
    clear_log();
    #3 reset_n = 1'b0;
    #1;
    // reset values
    chk("rst_in_ready",   in_ready,     1);
    chk("rst_ctrl_reset", ctrl_reset,   1);
    chk("rst_wr_en",      mem_write_en, 0);
    chk("rst_wr_addr",    mem_write_addr, 0);
    chk("rst_busy",       busy,         0);
    chk("rst_run_done",   run_done,     0);
    chk("rst_run_cycles", run_cycles,   0);
    chk("rst_inst_count", inst_count,   0);
    chk("rst_err_ovf",    err_overflow, 0);
    chk("rst_err_tmo",    err_timeout,  0);
    #18 reset_n = 1'b1;
    tick();

    // three words, continuous valid
    clear_log();
    send_word(32'h11, 1'b0);
    send_word(32'h22, 1'b0);
    send_word(32'h33, 1'b1);
    chk("t1_busy",      busy,       1);
    chk("t1_crst_k",    ctrl_reset, 1);
    tick();
    chk("t1_crst_k1",   ctrl_reset, 1);
    chk("t1_in_ready",  in_ready,   0);
    tick();
    chk("t1_crst_k2",   ctrl_reset, 0);
    chk("t1_inst_cnt",  inst_count, 3);
    chk("t1_nwr",       wr_addr.size(), 3);
    chk("t1_addr0",     wr_addr[0], 0);
    chk("t1_addr1",     wr_addr[1], 1);
    chk("t1_addr2",     wr_addr[2], 2);
    chk("t1_data0",     wr_data[0], 32'h11);
    chk("t1_data2",     wr_data[2], 32'h33);
    chk("t1_b2b_01",    wr_cyc[1] - wr_cyc[0], 1);
    chk("t1_b2b_12",    wr_cyc[2] - wr_cyc[1], 1);
    ctrl_done = 1'b1;
    tick();
    ctrl_done = 1'b0;
    chk("t1_run_done",   run_done,   1);
    chk("t1_run_cycles", run_cycles, 2);
    chk("t1_crst_done",  ctrl_reset, 1);
    tick();
    chk("t1_idle_busy",  busy,       0);

    // single word, done 5 cycles into RUN
    clear_log();
    send_word(32'h55, 1'b1);
    tick();
    repeat (4) tick();
    chk("t2_busy_run",   busy,       1);
    chk("t2_crst_run",   ctrl_reset, 0);
    ctrl_done = 1'b1;
    tick();
    ctrl_done = 1'b0;
    chk("t2_run_done",   run_done,   1);
    chk("t2_run_cycles", run_cycles, 5);
    chk("t2_crst_done",  ctrl_reset, 1);
    tick();
    chk("t2_run_done_lo", run_done,  0);
    chk("t2_busy_idle",  busy,       0);
    chk("t2_nwr",        wr_addr.size(), 1);
    chk("t2_addr",       wr_addr[0], 0);
    chk("t2_data",       wr_data[0], 32'h55);
    chk("t2_pulses",     done_pulses, 1);

    // overflow: MEMS+2 words
    clear_log();
    for (int i = 0; i < MEMS + 2; i++)
      send_word(32'h100 + i, (i == MEMS + 1));
    chk("t3_err_ovf",    err_overflow, 1);
    chk("t3_busy",       busy,         0);
    chk("t3_inst_cnt",   inst_count,   MEMS);
    repeat (4) tick();
    chk("t3_nwr",        wr_addr.size(), MEMS);
    chk("t3_last_addr",  wr_addr[MEMS-1], MEMS - 1);
    chk("t3_last_data",  wr_data[MEMS-1], 32'h100 + MEMS - 1);
    chk("t3_crst_low",   crst_low,     0);
    chk("t3_pulses",     done_pulses,  0);
    chk("t3_in_ready",   in_ready,     1);

    // gaps between beats; also clears the overflow flag; ctrl_done early
    clear_log();
    send_word(32'hA0, 1'b0);
    chk("t5_ovf_clr",    err_overflow, 0);
    repeat (4) tick();
    send_word(32'hA1, 1'b0);
    repeat (4) tick();
    send_word(32'hA2, 1'b1);
    ctrl_done = 1'b1;
    tick();
    chk("t5_done_ignored", run_done, 0);
    tick();
    ctrl_done = 1'b0;
    chk("t5_run_done",   run_done,   1);
    chk("t5_run_cycles", run_cycles, 1);
    tick();
    chk("t5_nwr",        wr_addr.size(), 3);
    chk("t5_addr1",      wr_addr[1], 1);
    chk("t5_addr2",      wr_addr[2], 2);
    chk("t5_data1",      wr_data[1], 32'hA1);
    chk("t5_gap",        wr_cyc[1] - wr_cyc[0], 5);

    // timeout with no ctrl_done
    clear_log();
    send_word(32'h77, 1'b1);
    repeat (TMO) tick();
    chk("t4_tmo_early",  err_timeout, 0);
    chk("t4_crst_run",   ctrl_reset,  0);
    tick();
    chk("t4_tmo",        err_timeout, 1);
    chk("t4_crst",       ctrl_reset,  1);
    chk("t4_busy",       busy,        0);
    tick();
    chk("t4_pulses",     done_pulses, 0);
    chk("t4_run_cycles", run_cycles,  1);

    // async reset during RUN
    send_word(32'h99, 1'b1);
    repeat (3) tick();
    chk("t6_crst_pre",   ctrl_reset, 0);
    reset_n = 1'b0;
    #1;
    chk("t6_crst",       ctrl_reset, 1);
    chk("t6_busy",       busy,       0);
    chk("t6_inst_cnt",   inst_count, 0);
    chk("t6_tmo_clr",    err_timeout, 0);
    #3 reset_n = 1'b1;
    tick();
    clear_log();
    send_word(32'hAB, 1'b0);
    send_word(32'hCD, 1'b1);
    tick();
    chk("t6_nwr",        wr_addr.size(), 2);
    chk("t6_addr0",      wr_addr[0], 0);
    chk("t6_data0",      wr_data[0], 32'hAB);
    chk("t6_inst_cnt2",  inst_count, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
